pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- RESET_PC, 32'h0000_0000, first fetch address.
- TRAP_VEC, 32'h0000_0080, trap target.
- WAIT_MAX, 16, ack timeout in cycles.

REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  consumer not ready for the presented instruction.
- jump  in  1  jump redirect, qualified by consume.
- jump_target  in  32  jump target address.
- br_taken  in  1  branch redirect, qualified by consume.
- br_target  in  32  branch target address.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction word.
- inst  out  32  held instruction.
- inst_valid  out  1  inst/pc valid.
- pc  out  32  address of inst.
- err  out  1  one-cycle timeout pulse.

Function
REQ-003 States SHALL be IDLE, REQ, WAIT and HOLD; IDLE is the reset state.
REQ-004 Transitions SHALL be:
- IDLE->REQ on the first clk after rst deasserts.
- REQ->WAIT unconditionally.
- WAIT->HOLD on imem_ack.
- HOLD->REQ on consume, where consume = inst_valid && !stall.
REQ-005 imem_req SHALL be high in REQ and WAIT, and imem_addr SHALL be stable while imem_req is high.
REQ-006 imem_ack SHALL be ignored outside WAIT.
REQ-007 On imem_ack in WAIT, inst SHALL load imem_rdata, pc SHALL load imem_addr and inst_valid SHALL rise, all on the same edge.
REQ-008 In HOLD with stall high, inst, pc and inst_valid SHALL hold indefinitely.
REQ-009 On consume, inst_valid SHALL fall and the next imem_addr SHALL be selected by priority jump > br_taken > pc+4.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0.
REQ-010 Redirect targets SHALL have bits [1:0] forced to 0.
REQ-011 jump and br_taken SHALL be ignored when consume is low.
REQ-012 Fetch latency SHALL be two cycles minimum: from consume to the next inst_valid with imem_ack in the first WAIT cycle.
REQ-013 A wait counter SHALL clear on entry to WAIT.
REQ-014 If WAIT_MAX cycles elapse without imem_ack:
- err pulses for one cycle.
- the state returns to REQ with the same address.

Reset
REQ-015 While rst is high, outputs SHALL be: imem_req=0, imem_addr=RESET_PC, inst=32'h0, inst_valid=0, pc=RESET_PC, err=0, state=IDLE.
REQ-016 rst asserted mid-WAIT SHALL abandon the outstanding fetch, and an imem_ack arriving after reset release SHALL be ignored.

Configuration
REQ-017 Macro PC_FETCH_TRAP_EN SHALL add port trap (in, 1) and port epc (out, 32), with epc reset value 32'h0.
REQ-018 With PC_FETCH_TRAP_EN, trap SHALL act in any state and outrank jump and branch:
- epc loads pc.
- inst_valid clears.
- any outstanding fetch is discarded (a late imem_ack is ignored).
- the next imem_addr is TRAP_VEC.
REQ-019 Without PC_FETCH_TRAP_EN, the trap and epc ports and all trap logic SHALL be absent.

Structure
REQ-020 Package pc_fetch_pkg SHALL hold:
- the state enum typedef.
- the constants RESET_PC_DEF, TRAP_VEC_DEF and PC_STEP=4.
REQ-021 The combinational next-PC priority mux SHALL be sub-module pc_next_sel; the FSM, registers and counter SHALL remain in pc_fetch_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release, ack one cycle after request -> imem_addr=0x0; inst_valid high with pc=0x0 and inst=rdata.
- Consume at pc=0x10 with br_taken=1, br_target=0x43 -> next imem_addr=0x40; jump=1 at the same time with jump_target=0x80 -> 0x80 instead.
- stall held high for 5 cycles in HOLD -> inst, pc and inst_valid unchanged; no imem_req until stall falls.
- No ack for 16 cycles -> one err pulse; request reissued to the same address.
- pc=0xFFFF_FFFC consumed with no redirect -> next imem_addr=0x0.
- PC_FETCH_TRAP_EN, trap mid-WAIT with pc=0x24 -> epc=0x24, late ack ignored, next imem_addr=0x80.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: fetch FSM state encoding and address constants for pc_fetch_ctrl.
package pc_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0080;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next fetch address, priority jump > branch > sequential pc+4.
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] next_pc
);
  always_comb
    next_pc = jump ? {jump_target[31:2], 2'b00} : br_taken ? {br_target[31:2], 2'b00} : pc + PC_STEP;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch FSM with redirect, hold/stall and ack timeout.
// Define PC_FETCH_TRAP_EN to add the trap input and epc output.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF,
  parameter int          WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic        err
`ifdef PC_FETCH_TRAP_EN
  ,
  input  logic        trap,
  output logic [31:0] epc
`endif
);
  localparam int CW = $clog2(WAIT_MAX) + 1;
  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d, inst_q, inst_d, pc_q, pc_d, next_pc;
  logic          valid_q, valid_d, err_q, err_d, consume;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef PC_FETCH_TRAP_EN
  logic [31:0]   epc_q, epc_d;
`endif
  assign consume    = valid_q && !stall;
  assign imem_req   = (state_q == REQ) || (state_q == WAIT);
  assign imem_addr  = addr_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign err        = err_q;
  pc_next_sel u_next (
    .pc         (pc_q),
    .jump       (jump),
    .jump_target(jump_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .next_pc    (next_pc)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef PC_FETCH_TRAP_EN
    epc_d   = epc_q;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (imem_ack) begin
          state_d = HOLD;
          inst_d  = imem_rdata;
          pc_d    = addr_q;
          valid_d = 1'b1;
        end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
          // timeout: reissue the same address
          state_d = REQ;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: if (consume) begin
        state_d = REQ;
        valid_d = 1'b0;
        addr_d  = next_pc;
      end
      default: state_d = IDLE;
    endcase
`ifdef PC_FETCH_TRAP_EN
    if (trap) begin
      state_d = REQ;
      epc_d   = pc_q;
      valid_d = 1'b0;
      addr_d  = TRAP_VEC;
      err_d   = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      inst_q  <= 32'h0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
`ifdef PC_FETCH_TRAP_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) epc_q <= 32'h0;
    else     epc_q <= epc_d;
  assign epc = epc_q;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, jump = 1'b0, br_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] jump_target = '0, br_target = '0, imem_rdata = '0;
  logic        imem_req, inst_valid, err;
  logic [31:0] imem_addr, inst, pc;
  int          passed = 0, total = 0;
`ifdef PC_FETCH_TRAP_EN
  logic        trap = 1'b0;
  logic [31:0] epc;
`endif
  always #5 clk = ~clk;
  pc_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .jump       (jump),
    .jump_target(jump_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .err        (err)
`ifdef PC_FETCH_TRAP_EN
    ,
    .trap       (trap),
    .epc        (epc)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic fetch(input logic [31:0] d);
    step();
    imem_ack = 1'b1;
    imem_rdata = d;
    step();
    imem_ack = 1'b0;
  endtask
  initial begin
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    fetch(32'hA000_0001);
    chk("first_valid", inst_valid, 1);
    chk("first_pc", pc, 32'h0);
    chk("first_inst", inst, 32'hA000_0001);
    chk("hold_req", imem_req, 0);
    stall = 1'b1;
    jump = 1'b1;
    jump_target = 32'h100;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_inst", inst, 32'hA000_0001);
      chk("stall_pc", pc, 32'h0);
      chk("stall_valid", inst_valid, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_addr", imem_addr, 32'h0);
    end
    jump = 1'b0;
    imem_ack = 1'b0;
    stall = 1'b0;
    step();
    chk("seq_addr", imem_addr, 32'h4);
    chk("seq_req", imem_req, 1);
    chk("seq_valid", inst_valid, 0);
    fetch(32'h11);
    chk("seq_pc", pc, 32'h4);
    jump = 1'b1;
    jump_target = 32'h10;
    step();
    jump = 1'b0;
    chk("jmp_addr", imem_addr, 32'h10);
    fetch(32'h22);
    chk("jmp_pc", pc, 32'h10);
    chk("jmp_inst", inst, 32'h22);
    br_taken = 1'b1;
    br_target = 32'h43;
    step();
    br_taken = 1'b0;
    chk("br_addr", imem_addr, 32'h40);
    step();
    chk("lat_valid1", inst_valid, 0);
    imem_ack = 1'b1;
    imem_rdata = 32'h33;
    step();
    imem_ack = 1'b0;
    chk("lat_valid2", inst_valid, 1);
    chk("br_pc", pc, 32'h40);
    jump = 1'b1;
    jump_target = 32'h10;
    step();
    jump = 1'b0;
    fetch(32'h44);
    chk("back_pc", pc, 32'h10);
    jump = 1'b1;
    jump_target = 32'h80;
    br_taken = 1'b1;
    br_target = 32'h43;
    step();
    jump = 1'b0;
    br_taken = 1'b0;
    chk("prio_addr", imem_addr, 32'h80);
    step();
    for (int i = 0; i < 15; i++) step();
    chk("to_noerr", err, 0);
    chk("to_req_wait", imem_req, 1);
    step();
    chk("to_err", err, 1);
    chk("to_addr", imem_addr, 32'h80);
    chk("to_req", imem_req, 1);
    step();
    chk("to_err_pulse", err, 0);
    imem_ack = 1'b1;
    imem_rdata = 32'h55;
    step();
    imem_ack = 1'b0;
    chk("to_pc", pc, 32'h80);
    chk("to_inst", inst, 32'h55);
    jump = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    fetch(32'h66);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    step();
    chk("mid_req", imem_req, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_valid", inst_valid, 0);
    chk("mid_rst_pc", pc, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'h77;
    step();
    step();
    rst = 1'b0;
    step();
    chk("late_ack_valid", inst_valid, 0);
    chk("late_ack_req", imem_req, 1);
    imem_ack = 1'b0;
    step();
`ifdef PC_FETCH_TRAP_EN
    chk("trap_epc_rst", epc, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'h88;
    step();
    imem_ack = 1'b0;
    jump = 1'b1;
    jump_target = 32'h24;
    step();
    jump = 1'b0;
    fetch(32'h99);
    chk("trap_pc", pc, 32'h24);
    step();
    step();
    trap = 1'b1;
    step();
    trap = 1'b0;
    chk("trap_epc", epc, 32'h24);
    chk("trap_valid", inst_valid, 0);
    chk("trap_addr", imem_addr, 32'h80);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("trap_late_ack", inst_valid, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
